pong_game_ctrl: RTL and testbench

- Central game-flow sequencer for the pong datapath. It replaces the ad-hoc top-level FSM plus the separate timer.
- Drives the graphics freeze (gra_still), score clear/increment, ball budget, serve direction and rally speed level.
- Timing comes from the 60 Hz frame tick.
- Sits between the input layer (buttons/keyboard, already muxed) and the pong_graph, score_counter and pong_text units.

---
 rtl/pong_game_ctrl.sv | 148 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for pong: serve/play/pause/over sequencing, frame-tick wait timer,
// ball budget, serve direction and rally speed level. All outputs are registered.
module pong_game_ctrl #(
   parameter int BALLS          = 3,
   parameter int SERVE_FRAMES   = 120,
   parameter int OVER_FRAMES    = 120,
   parameter int HITS_PER_LEVEL = 4,
   parameter int MAX_LEVEL      = 3
) (
   input  logic       top_clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic [1:0] hit,
   input  logic [1:0] miss,
   output logic       gra_still,
   output logic       d_clr,
   output logic [1:0] score_inc,
   output logic [3:0] balls_left,
   output logic       serve_dir,
   output logic [1:0] speed_level,
   output logic [7:0] countdown,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [3:0] BALLS_V = 4'(BALLS);
   localparam logic [7:0] SERVE_V = 8'(SERVE_FRAMES);
   localparam logic [7:0] OVER_V  = 8'(OVER_FRAMES);
   localparam logic [3:0] HITS_V  = 4'(HITS_PER_LEVEL);
   localparam logic [1:0] MAX_V   = 2'(MAX_LEVEL);

   state_t     cur, nxt;
   logic [3:0] hits, hits_n, balls_n;
   logic [7:0] cd_n;
   logic [1:0] lvl_n, sinc_n;
   logic       dir_n;
   logic       start_q, pause_q;
   logic       start_rise, pause_rise;

   assign start_rise = start_btn & ~start_q;
   assign pause_rise = pause_btn & ~pause_q;
   assign state      = cur;

   always_comb begin
      nxt     = cur;
      cd_n    = countdown;
      balls_n = balls_left;
      dir_n   = serve_dir;
      lvl_n   = speed_level;
      hits_n  = hits;
      sinc_n  = 2'b00;
      case (cur)
         IDLE: begin
            balls_n = BALLS_V;
            lvl_n   = 2'd0;
            hits_n  = 4'd0;
            cd_n    = 8'd0;
            if (start_rise) begin
               nxt  = SERVE;
               cd_n = SERVE_V;
            end
         end
         SERVE: begin
            if (frame_tick && countdown != 8'd0) cd_n = countdown - 8'd1;
            // An early press is simply dropped; only a fresh press after the wait serves.
            if (start_rise && countdown == 8'd0) nxt = PLAY;
         end
         PLAY: begin
            cd_n = 8'd0;
            if (miss != 2'b00) begin
               sinc_n  = miss;
               lvl_n   = 2'd0;
               hits_n  = 4'd0;
               if (miss == 2'b01)      dir_n = 1'b1;
               else if (miss == 2'b10) dir_n = 1'b0;
               balls_n = balls_left - 4'd1;
               if (balls_left == 4'd1) begin
                  nxt  = OVER;
                  cd_n = OVER_V;
               end else begin
                  nxt  = SERVE;
                  cd_n = SERVE_V;
               end
            end else begin
               if (hit != 2'b00) begin
                  if (hits == HITS_V - 4'd1) begin
                     hits_n = 4'd0;
                     lvl_n  = (speed_level < MAX_V) ? speed_level + 2'd1 : MAX_V;
                  end else begin
                     hits_n = hits + 4'd1;
                  end
               end
               if (pause_rise) nxt = PAUSE;
            end
         end
         PAUSE: begin
            if (pause_rise) nxt = PLAY;
         end
         OVER: begin
            if (countdown == 8'd0) nxt = IDLE;
            else if (frame_tick)   cd_n = countdown - 8'd1;
         end
         default: begin
            nxt  = IDLE;
            cd_n = 8'd0;
         end
      endcase
   end

   always_ff @(posedge top_clk) begin
      if (reset) begin
         cur         <= IDLE;
         gra_still   <= 1'b1;
         d_clr       <= 1'b0;
         score_inc   <= 2'b00;
         balls_left  <= BALLS_V;
         serve_dir   <= 1'b0;
         speed_level <= 2'd0;
         countdown   <= 8'd0;
         hits        <= 4'd0;
         start_q     <= 1'b0;
         pause_q     <= 1'b0;
      end else begin
         cur         <= nxt;
         // Freeze and clear follow the state being entered so they switch on the same edge.
         gra_still   <= (nxt != PLAY);
         d_clr       <= (nxt == IDLE);
         score_inc   <= sinc_n;
         balls_left  <= balls_n;
         serve_dir   <= dir_n;
         speed_level <= lvl_n;
         countdown   <= cd_n;
         hits        <= hits_n;
         start_q     <= start_btn;
         pause_q     <= pause_btn;
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios plus a randomized run against a rally-level model.
module tb_pong_game_ctrl;

   localparam int BALLS = 3;
   localparam int SF    = 120;
   localparam int OF    = 120;
   localparam int HPL   = 4;
   localparam int ML    = 3;

   logic       top_clk = 1'b0;
   logic       reset, frame_tick, start_btn, pause_btn;
   logic [1:0] hit, miss;
   logic       gra_still, d_clr, serve_dir;
   logic [1:0] score_inc, speed_level;
   logic [3:0] balls_left;
   logic [7:0] countdown;
   logic [2:0] state;

   int n_chk = 0;
   int n_bad = 0;

   // model state: speed level is derived from total hits in the current rally
   logic [2:0] m_state;
   logic [7:0] m_cd;
   logic [3:0] m_balls;
   logic       m_dir, m_gs, m_clr, m_ps, m_pp;
   logic [1:0] m_sinc;
   int         m_rally;

   pong_game_ctrl #(.BALLS(BALLS), .SERVE_FRAMES(SF), .OVER_FRAMES(OF),
                    .HITS_PER_LEVEL(HPL), .MAX_LEVEL(ML)) dut (
      .top_clk(top_clk), .reset(reset), .frame_tick(frame_tick),
      .start_btn(start_btn), .pause_btn(pause_btn), .hit(hit), .miss(miss),
      .gra_still(gra_still), .d_clr(d_clr), .score_inc(score_inc),
      .balls_left(balls_left), .serve_dir(serve_dir), .speed_level(speed_level),
      .countdown(countdown), .state(state)
   );

   always #5 top_clk = ~top_clk;

   wire [21:0] dut_vec = {state, gra_still, d_clr, score_inc, balls_left,
                          serve_dir, speed_level, countdown};

   function automatic logic [1:0] m_lvl();
      int q;
      q = m_rally / HPL;
      return (q > ML) ? 2'(ML) : 2'(q);
   endfunction

   function automatic logic [21:0] m_vec();
      return {m_state, m_gs, m_clr, m_sinc, m_balls, m_dir, m_lvl(), m_cd};
   endfunction

   task automatic model_step();
      logic sr, pr;
      if (reset) begin
         m_state = 3'd0; m_cd = 8'd0; m_balls = 4'(BALLS); m_dir = 1'b0;
         m_rally = 0; m_sinc = 2'b00; m_gs = 1'b1; m_clr = 1'b0;
         m_ps = 1'b0; m_pp = 1'b0;
      end else begin
         sr = start_btn && !m_ps;
         pr = pause_btn && !m_pp;
         m_ps = start_btn;
         m_pp = pause_btn;
         m_sinc = 2'b00;
         case (m_state)
            3'd0: begin
               m_balls = 4'(BALLS); m_rally = 0; m_cd = 8'd0;
               if (sr) begin m_state = 3'd1; m_cd = 8'(SF); end
            end
            3'd1: begin
               if (sr && m_cd == 0) m_state = 3'd2;
               else if (frame_tick && m_cd > 0) m_cd = m_cd - 8'd1;
            end
            3'd2: begin
               m_cd = 8'd0;
               if (miss != 2'b00) begin
                  m_sinc = miss;
                  m_rally = 0;
                  if (miss == 2'b01) m_dir = 1'b1;
                  else if (miss == 2'b10) m_dir = 1'b0;
                  m_balls = m_balls - 4'd1;
                  if (m_balls == 0) begin m_state = 3'd4; m_cd = 8'(OF); end
                  else begin m_state = 3'd1; m_cd = 8'(SF); end
               end else begin
                  if (hit != 2'b00) m_rally++;
                  if (pr) m_state = 3'd3;
               end
            end
            3'd3: if (pr) m_state = 3'd2;
            3'd4: begin
               if (m_cd == 0) m_state = 3'd0;
               else if (frame_tick) m_cd = m_cd - 8'd1;
            end
            default: m_state = 3'd0;
         endcase
         m_gs  = (m_state != 3'd2);
         m_clr = (m_state == 3'd0);
      end
   endtask

   task automatic step();
      @(posedge top_clk);
      model_step();
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1; step();
         frame_tick = 1'b0; step();
      end
   endtask

   task automatic press_start();
      start_btn = 1'b1; step();
      start_btn = 1'b0; step();
   endtask

   task automatic pulse_hit(input int n);
      for (int i = 0; i < n; i++) begin
         hit = 2'b01; step();
         hit = 2'b00; step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; frame_tick = 0; start_btn = 0; pause_btn = 0; hit = 0; miss = 0;
      repeat (3) step();
      n_chk++;
      if (dut_vec !== m_vec() || d_clr !== 1'b0) begin
         n_bad++; $display("FAIL reset_hold got=%h exp=%h", dut_vec, m_vec());
      end
      reset = 1'b0;
      step();
      n_chk++;
      if (state !== 3'd0 || gra_still !== 1'b1 || d_clr !== 1'b1 || balls_left !== 4'd3 ||
          countdown !== 8'd0) begin
         n_bad++; $display("FAIL reset_release got=%h", dut_vec);
      end
      n_chk++;
      if (dut_vec !== m_vec()) begin
         n_bad++; $display("FAIL reset_model got=%h exp=%h", dut_vec, m_vec());
      end
   endtask

   task automatic test_serve();
      start_btn = 1'b1; step();
      n_chk++;
      if (state !== 3'd1 || countdown !== 8'(SF) || d_clr !== 1'b0) begin
         n_bad++; $display("FAIL serve_entry got st=%0d cd=%0d clr=%b exp st=1 cd=%0d clr=0", state, countdown, d_clr, SF);
      end
      start_btn = 1'b0; step();
      tick(60);
      press_start();
      n_chk++;
      if (state !== 3'd1 || countdown !== 8'd60) begin
         n_bad++; $display("FAIL serve_early_press got st=%0d cd=%0d exp st=1 cd=60", state, countdown);
      end
      tick(60);
      start_btn = 1'b1; step();
      n_chk++;
      if (state !== 3'd2 || gra_still !== 1'b0 || dut_vec !== m_vec()) begin
         n_bad++; $display("FAIL serve_to_play got=%h exp st=2 still=0", dut_vec);
      end
      start_btn = 1'b0; step();
   endtask

   task automatic test_speed();
      pulse_hit(8);
      n_chk++;
      if (speed_level !== 2'd2) begin
         n_bad++; $display("FAIL speed_8hits got=%0d exp=2", speed_level);
      end
      pulse_hit(4);
      n_chk++;
      if (speed_level !== 2'd3) begin
         n_bad++; $display("FAIL speed_12hits got=%0d exp=3", speed_level);
      end
      pulse_hit(4);
      n_chk++;
      if (speed_level !== 2'd3 || dut_vec !== m_vec()) begin
         n_bad++; $display("FAIL speed_saturate got=%0d exp=3", speed_level);
      end
      miss = 2'b10; step(); miss = 2'b00;
      n_chk++;
      if (score_inc !== 2'b10 || speed_level !== 2'd0 || balls_left !== 4'd2 ||
          state !== 3'd1 || serve_dir !== 1'b0) begin
         n_bad++; $display("FAIL miss_right got=%h", dut_vec);
      end
      step();
      n_chk++;
      if (score_inc !== 2'b00) begin
         n_bad++; $display("FAIL miss_pulse_len got=%b exp=00", score_inc);
      end
   endtask

   task automatic test_priority();
      tick(SF);
      press_start();
      hit = 2'b01; miss = 2'b01; pause_btn = 1'b1; step();
      hit = 2'b00; miss = 2'b00; pause_btn = 1'b0;
      n_chk++;
      if (score_inc !== 2'b01 || state !== 3'd1 || serve_dir !== 1'b1 || balls_left !== 4'd1) begin
         n_bad++; $display("FAIL miss_priority got=%h", dut_vec);
      end
      step();
      tick(SF);
      press_start();
      pulse_hit(3);
      n_chk++;
      if (speed_level !== 2'd0) begin
         n_bad++; $display("FAIL hitcnt_cleared_3 got=%0d exp=0", speed_level);
      end
      pulse_hit(1);
      n_chk++;
      if (speed_level !== 2'd1 || dut_vec !== m_vec()) begin
         n_bad++; $display("FAIL hitcnt_cleared_4 got=%0d exp=1", speed_level);
      end
   endtask

   task automatic test_over();
      miss = 2'b11; step(); miss = 2'b00;
      n_chk++;
      if (state !== 3'd4 || balls_left !== 4'd0 || countdown !== 8'(OF) ||
          score_inc !== 2'b11 || serve_dir !== 1'b1) begin
         n_bad++; $display("FAIL over_entry got=%h", dut_vec);
      end
      start_btn = 1'b1; step(); start_btn = 1'b0;
      tick(OF - 1);
      n_chk++;
      if (state !== 3'd4 || countdown !== 8'd1 || balls_left !== 4'd0) begin
         n_bad++; $display("FAIL over_hold got st=%0d cd=%0d exp st=4 cd=1", state, countdown);
      end
      tick(1);
      step();
      n_chk++;
      if (state !== 3'd0 || balls_left !== 4'd3 || d_clr !== 1'b1 || dut_vec !== m_vec()) begin
         n_bad++; $display("FAIL over_to_idle got=%h exp=%h", dut_vec, m_vec());
      end
   endtask

   task automatic test_pause();
      press_start();
      tick(SF);
      press_start();
      pause_btn = 1'b1; step();
      n_chk++;
      if (state !== 3'd3 || gra_still !== 1'b1) begin
         n_bad++; $display("FAIL pause_enter got st=%0d still=%b exp st=3 still=1", state, gra_still);
      end
      repeat (3) step();
      pause_btn = 1'b0;
      miss = 2'b01; hit = 2'b10; step(); miss = 2'b00; hit = 2'b00;
      n_chk++;
      if (score_inc !== 2'b00 || state !== 3'd3) begin
         n_bad++; $display("FAIL pause_miss got sinc=%b st=%0d exp sinc=00 st=3", score_inc, state);
      end
      tick(10);
      n_chk++;
      if (state !== 3'd3 || balls_left !== 4'd3 || countdown !== 8'd0 || dut_vec !== m_vec()) begin
         n_bad++; $display("FAIL pause_ticks got=%h exp=%h", dut_vec, m_vec());
      end
      pause_btn = 1'b1; step(); pause_btn = 1'b0;
      n_chk++;
      if (state !== 3'd2 || gra_still !== 1'b0) begin
         n_bad++; $display("FAIL pause_exit got st=%0d exp=2", state);
      end
      step();
      reset = 1'b1; miss = 2'b01; step(); reset = 1'b0; miss = 2'b00;
      n_chk++;
      if (state !== 3'd0 || score_inc !== 2'b00 || dut_vec !== m_vec()) begin
         n_bad++; $display("FAIL reset_mid_play got=%h exp=%h", dut_vec, m_vec());
      end
   endtask

   task automatic test_random();
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         reset      = ($urandom_range(999) == 0);
         frame_tick = ($urandom_range(2) == 0);
         if ($urandom_range(7) == 0)  start_btn = ~start_btn;
         if ($urandom_range(15) == 0) pause_btn = ~pause_btn;
         hit  = ($urandom_range(3) == 0)  ? 2'($urandom_range(3))    : 2'b00;
         miss = ($urandom_range(29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         step();
         n_chk++;
         if (dut_vec !== m_vec()) begin
            n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, m_vec());
         end
      end
      reset = 1'b0; frame_tick = 0; start_btn = 0; pause_btn = 0; hit = 0; miss = 0;
   endtask

   initial begin
      test_reset();
      test_serve();
      test_speed();
      test_priority();
      test_over();
      test_pause();
      test_random();
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
